// File: rtl/dice_pkg.sv
// Shared types and default sizing for the dice turn scheduler.
package dice_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRST  = 2'd1,
        PLAY  = 2'd2,
        CLOSE = 2'd3
    } state_t;

    localparam int DEF_NUM_PLAYERS = 4;
    localparam int DEF_SCORE_W     = 8;
    localparam int DEF_TIMEOUT     = 16;

endpackage

// File: rtl/dice_turn_sched_rr_pick.sv
// Combinational round-robin selector: first set request at or after ptr, wrapping.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [IW-1:0] idx,
    output logic          valid
);

    logic [IW:0]   sum;
    logic [IW-1:0] pos;

    // Scan offsets from farthest to nearest so the nearest hit to ptr is written last.
    always_comb begin
        idx   = '0;
        valid = 1'b0;
        sum   = '0;
        pos   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            sum = {1'b0, ptr} + (IW + 1)'(k);
            if (sum >= (IW + 1)'(N)) begin
                sum = sum - (IW + 1)'(N);
            end
            pos = sum[IW-1:0];
            if (req[pos]) begin
                idx   = pos;
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dice_turn_sched.sv
// Shares one dice_game among NUM_PLAYERS players: round-robin turns, game reset
// per turn, roll-button pass-through, watchdog forfeit and per-player win counters.
module dice_turn_sched
    import dice_pkg::*;
#(
    parameter int NUM_PLAYERS = DEF_NUM_PLAYERS,
    parameter int SCORE_W     = DEF_SCORE_W,
    parameter int TIMEOUT     = DEF_TIMEOUT
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_PLAYERS-1:0]         req,
    output logic [NUM_PLAYERS-1:0]         grant,
    output logic                           game_rb,
    output logic                           game_reset,
    input  logic                           game_win,
    input  logic                           game_lose,
    output logic                           turn_done,
    output logic                           turn_won,
    output logic [$clog2(NUM_PLAYERS)-1:0] turn_player,
    output logic [NUM_PLAYERS*SCORE_W-1:0] wins_flat
);

    localparam int PW  = $clog2(NUM_PLAYERS);
    localparam int WDW = $clog2(TIMEOUT + 1);

    state_t         state_q, state_d;
    logic [PW-1:0]  cur_q, cur_d;
    logic [PW-1:0]  ptr_q, ptr_d;
    logic [PW-1:0]  player_q, player_d;
    logic           won_q, won_d;
    logic [WDW-1:0] wd_q, wd_d;

    logic [PW-1:0]  pick_idx;
    logic           pick_valid;
    logic           req_cur;
    logic [WDW-1:0] wd_inc;

    rr_pick #(
        .N  (NUM_PLAYERS),
        .IW (PW)
    ) u_pick (
        .req   (req),
        .ptr   (ptr_q),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    assign req_cur     = req[cur_q];
    assign wd_inc      = wd_q + WDW'(1);
    assign turn_won    = won_q;
    assign turn_player = player_q;

    always_comb begin
        state_d    = state_q;
        cur_d      = cur_q;
        ptr_d      = ptr_q;
        player_d   = player_q;
        won_d      = won_q;
        wd_d       = wd_q;
        grant      = '0;
        game_rb    = 1'b0;
        game_reset = 1'b1;
        turn_done  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    cur_d   = pick_idx;
                    state_d = GRST;
                end
            end

            GRST: begin
                grant   = NUM_PLAYERS'(1) << cur_q;
                wd_d    = '0;
                state_d = PLAY;
            end

            PLAY: begin
                game_reset = 1'b0;
                grant      = NUM_PLAYERS'(1) << cur_q;
                game_rb    = req_cur;
                wd_d       = req_cur ? '0 : wd_inc;
                // Win beats lose when both arrive together; forfeit only if neither.
                if (game_win) begin
                    won_d    = 1'b1;
                    player_d = cur_q;
                    state_d  = CLOSE;
                end else if (game_lose) begin
                    won_d    = 1'b0;
                    player_d = cur_q;
                    state_d  = CLOSE;
                end else if (!req_cur && (wd_inc == WDW'(TIMEOUT))) begin
                    won_d    = 1'b0;
                    player_d = cur_q;
                    state_d  = CLOSE;
                end
            end

            CLOSE: begin
                turn_done = 1'b1;
                ptr_d     = (cur_q == PW'(NUM_PLAYERS - 1)) ? '0 : cur_q + PW'(1);
                state_d   = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cur_q    <= '0;
            ptr_q    <= '0;
            player_q <= '0;
            won_q    <= 1'b0;
            wd_q     <= '0;
        end else begin
            state_q  <= state_d;
            cur_q    <= cur_d;
            ptr_q    <= ptr_d;
            player_q <= player_d;
            won_q    <= won_d;
            wd_q     <= wd_d;
        end
    end

    for (genvar gi = 0; gi < NUM_PLAYERS; gi++) begin : g_score
        logic [SCORE_W-1:0] cnt_q, cnt_d;

        always_comb begin
            cnt_d = cnt_q;
            if ((state_q == CLOSE) && won_q && (cur_q == PW'(gi))
                    && (cnt_q != {SCORE_W{1'b1}})) begin
                cnt_d = cnt_q + SCORE_W'(1);
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_d;
            end
        end

        assign wins_flat[gi*SCORE_W +: SCORE_W] = cnt_q;
    end

endmodule

// File: tb/tb_dice_turn_sched.sv
// Directed vector table plus hand sequences for timeout, saturation and mid-turn reset.
module tb_dice_turn_sched;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic [3:0]  grant;
    logic        game_rb;
    logic        game_reset;
    logic        game_win;
    logic        game_lose;
    logic        turn_done;
    logic        turn_won;
    logic [1:0]  turn_player;
    logic [31:0] wins_flat;

    int n_run  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    dice_turn_sched #(
        .NUM_PLAYERS (4),
        .SCORE_W     (8),
        .TIMEOUT     (16)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .grant       (grant),
        .game_rb     (game_rb),
        .game_reset  (game_reset),
        .game_win    (game_win),
        .game_lose   (game_lose),
        .turn_done   (turn_done),
        .turn_won    (turn_won),
        .turn_player (turn_player),
        .wins_flat   (wins_flat)
    );

    typedef struct packed {
        logic        rst;
        logic [3:0]  req;
        logic        win;
        logic        lose;
        logic [3:0]  grant;
        logic        rb;
        logic        grst;
        logic        done;
        logic        won;
        logic [1:0]  player;
        logic [31:0] wins;
    } vec_t;

    vec_t vecs [18];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // One full winning turn for player p, starting and ending in IDLE.
    task automatic play_win(input int p);
        @(negedge clk);
        req      = 4'b0001 << p;
        game_win = 1'b0;
        @(negedge clk);
        req = 4'b0000;
        @(negedge clk);
        game_win = 1'b1;
        @(negedge clk);
        game_win = 1'b0;
        #1;
        chk("win_done", 64'(turn_done), 64'd1);
        chk("win_player", 64'(turn_player), 64'(p));
        @(negedge clk);
    endtask

    initial begin
        //         rst req      w  l  grant    rb grst done won player wins
        vecs[0]  = '{1'b1, 4'b0001, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 32'h0000_0000};
        vecs[1]  = '{1'b0, 4'b0001, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 32'h0000_0000};
        vecs[2]  = '{1'b0, 4'b0001, 1'b0, 1'b0, 4'b0001, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 32'h0000_0000};
        vecs[3]  = '{1'b0, 4'b0001, 1'b0, 1'b0, 4'b0001, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0000_0000};
        vecs[4]  = '{1'b0, 4'b0000, 1'b0, 1'b0, 4'b0001, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0000_0000};
        vecs[5]  = '{1'b0, 4'b0001, 1'b1, 1'b0, 4'b0001, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0000_0000};
        vecs[6]  = '{1'b0, 4'b0001, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b1, 1'b1, 2'd0, 32'h0000_0000};
        vecs[7]  = '{1'b0, 4'b1010, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 32'h0000_0001};
        vecs[8]  = '{1'b0, 4'b1010, 1'b0, 1'b0, 4'b0010, 1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 32'h0000_0001};
        vecs[9]  = '{1'b0, 4'b1010, 1'b0, 1'b0, 4'b0010, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 32'h0000_0001};
        vecs[10] = '{1'b0, 4'b1010, 1'b0, 1'b1, 4'b0010, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 32'h0000_0001};
        vecs[11] = '{1'b0, 4'b1010, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b1, 1'b0, 2'd1, 32'h0000_0001};
        vecs[12] = '{1'b0, 4'b1010, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 2'd1, 32'h0000_0001};
        vecs[13] = '{1'b0, 4'b1010, 1'b0, 1'b0, 4'b1000, 1'b0, 1'b1, 1'b0, 1'b0, 2'd1, 32'h0000_0001};
        vecs[14] = '{1'b0, 4'b1010, 1'b0, 1'b0, 4'b1000, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 32'h0000_0001};
        vecs[15] = '{1'b0, 4'b1010, 1'b1, 1'b1, 4'b1000, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 32'h0000_0001};
        vecs[16] = '{1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b1, 1'b1, 2'd3, 32'h0000_0001};
        vecs[17] = '{1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b1, 2'd3, 32'h0100_0001};

        reset     = 1'b1;
        req       = 4'b0000;
        game_win  = 1'b0;
        game_lose = 1'b0;
        repeat (3) @(negedge clk);

        // Tests 1, 2 and 4: win by player 0, lose by player 1, simultaneous win/lose by player 3.
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            reset     = vecs[i].rst;
            req       = vecs[i].req;
            game_win  = vecs[i].win;
            game_lose = vecs[i].lose;
            #1;
            chk("grant", 64'(grant), 64'(vecs[i].grant));
            chk("game_rb", 64'(game_rb), 64'(vecs[i].rb));
            chk("game_reset", 64'(game_reset), 64'(vecs[i].grst));
            chk("turn_done", 64'(turn_done), 64'(vecs[i].done));
            chk("turn_won", 64'(turn_won), 64'(vecs[i].won));
            chk("turn_player", 64'(turn_player), 64'(vecs[i].player));
            chk("wins_flat", 64'(wins_flat), 64'(vecs[i].wins));
            $display("[TB] vec %0d req=%b grant=%b rb=%b grst=%b done=%b won=%b player=%0d wins=%h",
                     i, req, grant, game_rb, game_reset, turn_done, turn_won, turn_player, wins_flat);
        end

        // Test 3: player 2 idles in PLAY until the watchdog forfeits the turn.
        @(negedge clk);
        req = 4'b0100;
        @(negedge clk);
        req = 4'b0000;
        #1;
        chk("to_grst_grant", 64'(grant), 64'b0100);
        chk("to_grst_reset", 64'(game_reset), 64'd1);
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            #1;
            chk("to_play_done", 64'(turn_done), 64'd0);
            chk("to_play_grant", 64'(grant), 64'b0100);
        end
        @(negedge clk);
        #1;
        chk("to_close_done", 64'(turn_done), 64'd1);
        chk("to_close_won", 64'(turn_won), 64'd0);
        chk("to_close_player", 64'(turn_player), 64'd2);
        @(negedge clk);
        #1;
        chk("to_wins", 64'(wins_flat), 64'h0100_0001);
        $display("[TB] timeout forfeit player=%0d won=%b wins=%h", turn_player, turn_won, wins_flat);

        // Test 5: drive player 0 to saturation, then one more win.
        for (int n = 0; n < 254; n++) begin
            play_win(0);
        end
        chk("sat_reach", 64'(wins_flat), 64'h0100_00FF);
        play_win(0);
        chk("sat_hold", 64'(wins_flat), 64'h0100_00FF);
        $display("[TB] saturation wins=%h", wins_flat);

        // Test 6: reset during player 3's PLAY discards the turn.
        @(negedge clk);
        req = 4'b1000;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst_pre_grant", 64'(grant), 64'b1000);
        chk("rst_pre_reset", 64'(game_reset), 64'd0);
        reset = 1'b1;
        @(negedge clk);
        #1;
        chk("rst_grant", 64'(grant), 64'd0);
        chk("rst_game_reset", 64'(game_reset), 64'd1);
        chk("rst_wins", 64'(wins_flat), 64'd0);
        chk("rst_done", 64'(turn_done), 64'd0);
        chk("rst_player", 64'(turn_player), 64'd0);
        @(negedge clk);
        #1;
        chk("rst_done2", 64'(turn_done), 64'd0);
        reset = 1'b0;
        req   = 4'b0000;
        @(negedge clk);
        #1;
        chk("post_rst_grant", 64'(grant), 64'd0);
        $display("[TB] mid-turn reset grant=%b wins=%h", grant, wins_flat);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
